// File: rtl/agc_seq_pkg.sv
// agc_seq_pkg
//   Shared definitions for the AGC cycle sequencer: the FSM state encoding,
//   the default latch-acknowledge timeout, counter widths and a small helper
//   used to size the shared down-counter.
package agc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_ACCUM = 3'd2,
    ST_LATCH = 3'd3,
    ST_APPLY = 3'd4,
    ST_DONE  = 3'd5
  } agc_state_e;

  localparam int ACK_TIMEOUT_DEFAULT = 1024;
  localparam int CYCLE_CNT_W         = 16;
  localparam int RST_SYNC_STAGES     = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/agc_seq_timer.sv
// agc_seq_timer
//   Loadable down-counter shared by the RESET, ACCUM and LATCH phases.
//   A load of N makes term_o high during the Nth clock after the load edge,
//   so a state that transitions on term_o lasts exactly N clocks.
// Ports:
//   clk        - clock
//   rst_n      - asynchronous active-low reset
//   load_i     - load load_val_i (takes priority over counting)
//   load_val_i - value to load; must be non-zero
//   term_o     - terminal indication (count has reached 1)
module agc_seq_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         term_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Stops at zero after passing 1, so this is a single-clock pulse per load.
  assign term_o = (count_q == W'(1));

endmodule

// File: rtl/agc_cycle_sequencer.sv
// agc_cycle_sequencer
//   Sequences one AGC cycle across NCHAN trigger-chain channels:
//   reset accumulators, accumulate for period_i clocks, request a latch and
//   wait for its ack (with timeout), issue one apply per channel, then pulse
//   cycle_done_o. Runs once per start_i pulse, or back-to-back while enable_i.
// Ports:
//   wb_clk_i, wb_rst_n_i         - clock, asynchronous active-low reset
//   enable_i, start_i            - continuous enable / one-shot request
//   period_i                     - accumulation length, sampled leaving RESET
//   agc_reset_o                  - accumulator reset pulse
//   latch_req_o / latch_ack_i    - latch handshake
//   apply_valid_o/apply_chan_o/apply_ready_i - per-channel apply handshake
//   cycle_done_o, cycle_count_o  - end-of-cycle pulse and completed count
//   timeout_err_o, err_clr_i     - sticky latch timeout flag and its clear
//   busy_o                       - high whenever not idle
//   NCHAN must be at least 2; RESET_CYCLES and ACK_TIMEOUT at least 1.
module agc_cycle_sequencer
  import agc_seq_pkg::*;
#(
  parameter int NCHAN        = 8,
  parameter int PERIOD_BITS  = 24,
  parameter int RESET_CYCLES = 4,
  parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEFAULT
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  input  logic                     enable_i,
  input  logic                     start_i,
  input  logic [PERIOD_BITS-1:0]   period_i,
  output logic                     agc_reset_o,
  output logic                     latch_req_o,
  input  logic                     latch_ack_i,
  output logic                     apply_valid_o,
  output logic [$clog2(NCHAN)-1:0] apply_chan_o,
  input  logic                     apply_ready_i,
  output logic                     cycle_done_o,
  output logic [CYCLE_CNT_W-1:0]   cycle_count_o,
  output logic                     timeout_err_o,
  input  logic                     err_clr_i,
  output logic                     busy_o
);

  localparam int CW = $clog2(NCHAN);
  localparam int TW = max3(PERIOD_BITS, $clog2(ACK_TIMEOUT + 1), $clog2(RESET_CYCLES + 1));

  // Reset release synchroniser: assertion is immediate, release is seen by
  // the FSM only once the last stage has clocked in a one.
  logic [RST_SYNC_STAGES-1:0] rst_sync_q;
  logic                       run;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[RST_SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign run = rst_sync_q[RST_SYNC_STAGES-1];

  agc_state_e             state_q, state_d;
  logic [CW-1:0]          chan_q, chan_d;
  logic [CYCLE_CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic                   err_q, err_d;
  logic                   agc_reset_q, agc_reset_d;
  logic                   latch_req_q, latch_req_d;
  logic                   apply_valid_q, apply_valid_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;

  logic                   tmr_load;
  logic [TW-1:0]          tmr_val;
  logic                   tmr_term;
  logic [PERIOD_BITS-1:0] period_eff;

  agc_seq_timer #(
    .W(TW)
  ) u_timer (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n_i),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .term_o    (tmr_term)
  );

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    cycle_cnt_d = cycle_cnt_q;
    err_d       = err_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    // A zero period would never reach the terminal count; run it as one.
    period_eff  = (period_i == '0) ? PERIOD_BITS'(1) : period_i;

    // Clear first so that a timeout in the same clock overrides it.
    if (err_clr_i) begin
      err_d = 1'b0;
    end

    if (run) begin
      case (state_q)
        ST_IDLE: begin
          if (start_i || enable_i) begin
            state_d  = ST_RESET;
            tmr_load = 1'b1;
            tmr_val  = TW'(RESET_CYCLES);
          end
        end
        ST_RESET: begin
          if (tmr_term) begin
            state_d  = ST_ACCUM;
            tmr_load = 1'b1;
            tmr_val  = TW'(period_eff);
          end
        end
        ST_ACCUM: begin
          if (tmr_term) begin
            state_d  = ST_LATCH;
            tmr_load = 1'b1;
            tmr_val  = TW'(ACK_TIMEOUT);
          end
        end
        ST_LATCH: begin
          // An ack on the final timeout clock still counts as in time.
          if (latch_ack_i) begin
            state_d = ST_APPLY;
            chan_d  = '0;
          end else if (tmr_term) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
        ST_APPLY: begin
          // apply_valid_o is high throughout APPLY, so ready alone means a transfer.
          if (apply_ready_i) begin
            if (chan_q == CW'(NCHAN - 1)) begin
              state_d = ST_DONE;
            end else begin
              chan_d = chan_q + CW'(1);
            end
          end
        end
        ST_DONE: begin
          if (enable_i) begin
            state_d  = ST_RESET;
            tmr_load = 1'b1;
            tmr_val  = TW'(RESET_CYCLES);
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    agc_reset_d   = (state_d == ST_RESET);
    latch_req_d   = (state_d == ST_LATCH);
    apply_valid_d = (state_d == ST_APPLY);
    done_d        = (state_d == ST_DONE);
    busy_d        = (state_d != ST_IDLE);
    if (state_d == ST_DONE) begin
      cycle_cnt_d = cycle_cnt_q + CYCLE_CNT_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q       <= ST_IDLE;
      chan_q        <= '0;
      cycle_cnt_q   <= '0;
      err_q         <= 1'b0;
      agc_reset_q   <= 1'b0;
      latch_req_q   <= 1'b0;
      apply_valid_q <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      chan_q        <= chan_d;
      cycle_cnt_q   <= cycle_cnt_d;
      err_q         <= err_d;
      agc_reset_q   <= agc_reset_d;
      latch_req_q   <= latch_req_d;
      apply_valid_q <= apply_valid_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
    end
  end

  assign agc_reset_o   = agc_reset_q;
  assign latch_req_o   = latch_req_q;
  assign apply_valid_o = apply_valid_q;
  assign apply_chan_o  = chan_q;
  assign cycle_done_o  = done_q;
  assign cycle_count_o = cycle_cnt_q;
  assign timeout_err_o = err_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_agc_cycle_sequencer.sv
// tb_agc_cycle_sequencer
//   Directed bench with a scoreboard: each test pushes the events it expects
//   (apply transfers, cycle_done pulses with count, timeout rises) and an
//   independent monitor pops and compares them as the DUT presents them.
module tb_agc_cycle_sequencer;

  localparam int EV_APPLY = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_TMO   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable_i = 1'b0;
  logic        start_i = 1'b0;
  logic [23:0] period_i = '0;
  logic        agc_reset_o;
  logic        latch_req_o;
  logic        latch_ack_i = 1'b0;
  logic        apply_valid_o;
  logic [2:0]  apply_chan_o;
  logic        apply_ready_i = 1'b1;
  logic        cycle_done_o;
  logic [15:0] cycle_count_o;
  logic        timeout_err_o;
  logic        err_clr_i = 1'b0;
  logic        busy_o;

  always #5 clk = ~clk;

  agc_cycle_sequencer dut (
    .wb_clk_i     (clk),
    .wb_rst_n_i   (rst_n),
    .enable_i     (enable_i),
    .start_i      (start_i),
    .period_i     (period_i),
    .agc_reset_o  (agc_reset_o),
    .latch_req_o  (latch_req_o),
    .latch_ack_i  (latch_ack_i),
    .apply_valid_o(apply_valid_o),
    .apply_chan_o (apply_chan_o),
    .apply_ready_i(apply_ready_i),
    .cycle_done_o (cycle_done_o),
    .cycle_count_o(cycle_count_o),
    .timeout_err_o(timeout_err_o),
    .err_clr_i    (err_clr_i),
    .busy_o       (busy_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int kind;
    int val;
  } ev_t;
  ev_t exp_q[$];

  // Responder knobs, written only by the stimulus process.
  int ack_delay    = 0;  // clocks of latch_req before ack; -1 = never
  bit stray_en     = 1'b0; // hold ack high during ACCUM (must be ignored)
  bit ready_toggle = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic push_cycle(input int cnt);
    for (int c = 0; c < 8; c++) push_ev(EV_APPLY, c);
    push_ev(EV_DONE, cnt & 16'hFFFF);
  endtask

  task automatic observe(input int k, input int v);
    ev_t e;
    $display("t=%0t event kind=%0d val=0x%0h", $time, k, v);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_event: got kind=%0d val=0x%0h, expected none", k, v);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", k, e.kind);
      check("event_val", v, e.val);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic       prev_valid;
    logic       prev_ready;
    logic       prev_err;
    logic [2:0] prev_chan;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_err   = 1'b0;
    prev_chan  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_err   = 1'b0;
      end else begin
        if (prev_valid && !prev_ready) begin
          check("stall_valid", apply_valid_o, 1);
          check("stall_chan", apply_chan_o, prev_chan);
        end
        if (apply_valid_o && apply_ready_i) observe(EV_APPLY, int'(apply_chan_o));
        if (cycle_done_o) observe(EV_DONE, int'(cycle_count_o));
        if (timeout_err_o && !prev_err) observe(EV_TMO, 0);
        prev_valid = apply_valid_o;
        prev_ready = apply_ready_i;
        prev_chan  = apply_chan_o;
        prev_err   = timeout_err_o;
      end
    end
  end

  // Latch/apply responder: drives ack and ready just after each rising edge.
  initial begin
    int lat_cnt;
    lat_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      latch_ack_i = 1'b0;
      if (latch_req_o) begin
        if (ack_delay >= 0 && lat_cnt == ack_delay) latch_ack_i = 1'b1;
        lat_cnt++;
      end else begin
        lat_cnt = 0;
        if (stray_en && busy_o && !agc_reset_o && !apply_valid_o && !cycle_done_o)
          latch_ack_i = 1'b1;
      end
      if (ready_toggle) apply_ready_i = ~apply_ready_i;
      else apply_ready_i = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {agc_reset_o, latch_req_o, apply_valid_o, apply_chan_o, cycle_done_o,
                 cycle_count_o, timeout_err_o, busy_o}, 0);
  endtask

  task automatic count_agc(output int n);
    n = 0;
    @(negedge clk);
    while (agc_reset_o && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic count_until_latch(output int n);
    n = 0;
    while (!latch_req_o && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic count_latch(output int n);
    n = 0;
    while (latch_req_o && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int limit, output int idle_seen);
    int k;
    k = 0;
    idle_seen = 0;
    @(negedge clk);
    while (!cycle_done_o && k < limit) begin
      if (!busy_o) idle_seen++;
      k++;
      @(negedge clk);
    end
    if (!cycle_done_o) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_wait: cycle_done_o=0 after %0d clocks, expected 1", limit);
    end
  endtask

  // Three enable-driven cycles; enable drops during ACCUM of the third.
  task automatic run_cont3(input int base);
    int idle, total_idle, k;
    push_cycle(base + 1);
    push_cycle(base + 2);
    push_cycle(base + 3);
    period_i   = 24'd10;
    ack_delay  = 0;
    enable_i   = 1'b1;
    tick();
    total_idle = 0;
    wait_done(300, idle);
    total_idle += idle;
    @(negedge clk);
    check("b2b_reset_1", agc_reset_o, 1);
    wait_done(300, idle);
    total_idle += idle;
    @(negedge clk);
    check("b2b_reset_2", agc_reset_o, 1);
    k = 0;
    while (agc_reset_o && k < 20) begin
      k++;
      @(negedge clk);
    end
    enable_i = 1'b0;
    wait_done(300, idle);
    total_idle += idle;
    check("cont_count", cycle_count_o, (base + 3) & 16'hFFFF);
    @(negedge clk);
    check("cont_idle_after", busy_o, 0);
    check("cont_no_idle_clock", total_idle, 0);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: time limit reached with %0d events pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int n, idle;

    // Reset state.
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_state");
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) tick();
    check_all_zero("post_release_idle");

    // Basic one-shot cycle: period 100, ack after 3 clocks, ready held high.
    period_i  = 24'd100;
    ack_delay = 3;
    push_cycle(1);
    pulse_start();
    count_agc(n);
    check("t1_agc_len", n, 4);
    count_until_latch(n);
    check("t1_accum_len", n, 100);
    count_latch(n);
    check("t1_latch_len", n, 4);
    wait_done(100, idle);
    @(negedge clk);
    check("t1_count", cycle_count_o, 1);
    check("t1_idle", busy_o, 0);

    // Ready toggling every clock, stray ack during ACCUM ignored.
    period_i     = 24'd7;
    ack_delay    = 2;
    stray_en     = 1'b1;
    ready_toggle = 1'b1;
    push_cycle(2);
    pulse_start();
    count_agc(n);
    check("t2_agc_len", n, 4);
    count_until_latch(n);
    check("t2_accum_len", n, 7);
    count_latch(n);
    check("t2_latch_len", n, 3);
    wait_done(100, idle);
    stray_en     = 1'b0;
    ready_toggle = 1'b0;
    @(negedge clk);
    check("t2_count", cycle_count_o, 2);

    // Latch timeout with period 0 (treated as 1), then clear.
    period_i  = 24'd0;
    ack_delay = -1;
    push_ev(EV_TMO, 0);
    pulse_start();
    count_agc(n);
    check("t3_agc_len", n, 4);
    count_until_latch(n);
    check("t3_accum_len_zero", n, 1);
    count_latch(n);
    check("t3_latch_timeout_len", n, 1024);
    check("t3_err_set", timeout_err_o, 1);
    check("t3_idle", busy_o, 0);
    check("t3_count_unchanged", cycle_count_o, 2);
    tick();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    @(negedge clk);
    check("t3_err_cleared", timeout_err_o, 0);

    // Timeout while err_clr_i is held: set wins.
    period_i  = 24'd3;
    err_clr_i = 1'b1;
    push_ev(EV_TMO, 0);
    pulse_start();
    count_agc(n);
    count_until_latch(n);
    check("t3b_accum_len", n, 3);
    count_latch(n);
    check("t3b_latch_len", n, 1024);
    check("t3b_set_wins", timeout_err_o, 1);
    err_clr_i = 1'b0;
    @(negedge clk);
    check("t3b_sticky", timeout_err_o, 1);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    @(negedge clk);
    check("t3b_err_cleared", timeout_err_o, 0);

    // Fresh counter, then three continuous cycles.
    rst_n = 1'b0;
    #1 check_all_zero("t4_reset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) tick();
    run_cont3(0);

    // Reset during APPLY at channel 5, then a fresh cycle.
    period_i  = 24'd5;
    ack_delay = 0;
    for (int c = 0; c <= 5; c++) push_ev(EV_APPLY, c);
    pulse_start();
    n = 0;
    while (!(apply_valid_o && apply_chan_o == 3'd5) && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("t5_reached_chan5", {apply_valid_o, apply_chan_o}, {1'b1, 3'd5});
    #1 rst_n = 1'b0;
    #1 check_all_zero("t5_async_reset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) tick();
    check_all_zero("t5_post_release");
    push_cycle(1);
    pulse_start();
    wait_done(100, idle);
    check("t5_fresh_count", cycle_count_o, 1);

    // Counter wrap: preload near the top, then run three cycles.
    @(negedge clk);
    dut.cycle_cnt_q = 16'hFFFD;
    run_cont3(16'hFFFD);
    check("t6_wrapped", cycle_count_o, 0);

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
